// File: rtl/proj_read_feeder.sv
// Host byte stream to 2-bit base stream feeder for the MinHash pipeline.
// Ping-pong read buffers; each full read is streamed as one unbroken burst.
module proj_read_feeder #(
  parameter int unsigned BASE_LEN = 2,
  parameter int unsigned READ_LEN = 150,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_char,
  input  logic                in_last,
  input  logic                down_wait,
  output logic [BASE_LEN-1:0] out_base,
  output logic                out_start,
  output logic                out_busy,
  output logic [CNT_W-1:0]    bad_char_cnt,
  output logic [CNT_W-1:0]    trunc_cnt,
  output logic [CNT_W-1:0]    pad_cnt
);

  localparam int unsigned PTR_W = $clog2(READ_LEN + 1);
  localparam int unsigned IDX_W = (READ_LEN > 1) ? $clog2(READ_LEN) : 1;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(READ_LEN);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;

  logic [BASE_LEN-1:0] mem [2][READ_LEN];
  logic [PTR_W-1:0]    bank_len [2];
  logic [1:0]          full, full_nxt;
  logic                wr_bank, wr_bank_nxt, wr_drop;
  logic [PTR_W-1:0]    wr_ptr, wr_cnt;
  logic                wr_fire, wr_store, wr_end, wr_bad;
  logic [BASE_LEN-1:0] wr_enc;
  logic                rd_bank, rd_done;
  logic [PTR_W-1:0]    rd_ptr, rd_idx;
  logic [BASE_LEN-1:0] rd_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    wr_enc = '0;
    wr_bad = 1'b0;
    case (in_char)
      8'h41, 8'h61: wr_enc = BASE_LEN'(0);
      8'h43, 8'h63: wr_enc = BASE_LEN'(1);
      8'h47, 8'h67: wr_enc = BASE_LEN'(2);
      8'h54, 8'h74: wr_enc = BASE_LEN'(3);
      default:      wr_bad = 1'b1;
    endcase
  end

  assign wr_fire  = in_valid & in_ready;
  assign wr_store = (wr_ptr != FULL_PTR);
  assign wr_end   = wr_fire & in_last;
  assign wr_cnt   = wr_ptr + PTR_W'(wr_store);
  assign rd_done  = (state == STREAM) && (rd_ptr == FULL_PTR);

  // The two sides never touch the same bank: write targets a non-full bank,
  // read only drains a full one.
  always_comb begin
    full_nxt = full;
    if (wr_end)  full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    wr_bank_nxt = wr_bank ^ wr_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full         <= '0;
      wr_bank      <= 1'b0;
      wr_ptr       <= '0;
      wr_drop      <= 1'b0;
      in_ready     <= 1'b0;
      bank_len[0]  <= '0;
      bank_len[1]  <= '0;
      bad_char_cnt <= '0;
      trunc_cnt    <= '0;
      pad_cnt      <= '0;
    end else begin
      full     <= full_nxt;
      wr_bank  <= wr_bank_nxt;
      in_ready <= !full_nxt[wr_bank_nxt];
      if (wr_fire) begin
        if (wr_bad) bad_char_cnt <= sat_inc(bad_char_cnt);
        if (in_last) begin
          // Positions at or beyond bank_len read back as 0, which gives the padding.
          bank_len[wr_bank] <= wr_cnt;
          if (wr_cnt != FULL_PTR)    pad_cnt   <= sat_inc(pad_cnt);
          if (wr_drop || !wr_store) trunc_cnt <= sat_inc(trunc_cnt);
          wr_ptr  <= '0;
          wr_drop <= 1'b0;
        end else if (wr_store) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end else begin
          wr_drop <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && wr_store) mem[wr_bank][wr_ptr[IDX_W-1:0]] <= wr_enc;
  end

  always_comb begin
    rd_idx  = (state == STREAM) ? rd_ptr : '0;
    rd_base = '0;
    if (rd_idx < bank_len[rd_bank]) rd_base = mem[rd_bank][rd_idx[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      out_base  <= '0;
      out_start <= 1'b0;
      out_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rd_bank] && !down_wait) begin
            state     <= STREAM;
            out_start <= 1'b1;
            out_busy  <= 1'b1;
            out_base  <= rd_base;
            rd_ptr    <= PTR_W'(1);
          end
        end
        STREAM: begin
          out_start <= 1'b0;
          if (rd_done) begin
            state    <= IDLE;
            out_busy <= 1'b0;
            out_base <= '0;
            rd_bank  <= ~rd_bank;
            rd_ptr   <= '0;
          end else begin
            out_base <= rd_base;
            rd_ptr   <= rd_ptr + PTR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/proj_read_feeder.md
Name: proj_read_feeder

Overview:
- Upstream stage of the MinHash pipeline top; converts a host byte stream of ASCII nucleotides into the 2-bit base stream and start pulse that the pipeline consumes.
- Buffers one complete read per bank in a ping-pong pair. Streams each read as an unbroken burst of READ_LEN bases, because the pipeline samples a base every cycle and has no per-base valid.
- Honours the pipeline's wait output as a burst-level stall.

Parameters:
- BASE_LEN, 2, bits per encoded base (from proj_pkg).
- READ_LEN, 150, bases per read streamed downstream.
- CNT_W, 16, width of the error/statistics counters.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  host byte valid.
- in_ready  output  1  feeder accepts byte this cycle.
- in_char  input  8  ASCII nucleotide.
- in_last  input  1  byte is final character of current read.
- down_wait  input  1  pipeline wait; high blocks the start of a new burst.
- out_base  output  BASE_LEN  encoded base to pipeline in_data.
- out_start  output  1  one-cycle pulse, coincident with base 0 of a burst.
- out_busy  output  1  burst in progress.
- bad_char_cnt  output  CNT_W  count of invalid characters.
- trunc_cnt  output  CNT_W  count of reads longer than READ_LEN.
- pad_cnt  output  CNT_W  count of reads shorter than READ_LEN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: all outputs 0, except in_ready, which is 1 one cycle after reset release. Both banks empty, write bank 0, read bank 0, all counters 0.
- Reset mid-burst: the burst aborts immediately and all buffered data is discarded.
- Encoding (case-insensitive): A=0, C=1, G=2, T=3. Any other byte, including N, encodes to 0 and increments bad_char_cnt.
- Counters saturate at all-ones.
- Handshake: a byte transfers when in_valid && in_ready.
- in_ready is high whenever the write bank is not full.
- Write side, per transferred byte:
  - Below READ_LEN bases: store the encoded base at the current write pointer.
  - READ_LEN bases already stored and in_last not yet seen: discard the byte.
- Write side, end of read (in_last transfers):
  - If fewer than READ_LEN bases were stored, the remaining positions read as 0 and pad_cnt increments.
  - If any byte was discarded, trunc_cnt increments once for that read.
  - The bank is marked full and the write side toggles to the other bank. in_ready drops if that bank is still full.
- A read of exactly READ_LEN bases ending with in_last: neither pad_cnt nor trunc_cnt changes.
- Read side FSM, IDLE -> STREAM -> IDLE:
  - IDLE: when the read bank is full and down_wait is 0, enter STREAM.
  - STREAM cycle 0: out_start=1, out_busy=1, out_base=base 0.
  - STREAM cycles 1..READ_LEN-1: out_base=base k, out_start=0.
  - After the last base: mark the bank empty, toggle the read bank, return to IDLE. out_busy=0 and out_base=0 in the next cycle.
- Back-to-back bursts: the earliest next out_start is one cycle after the last base of the previous burst, giving one idle cycle minimum.
- down_wait is sampled only in IDLE. Assertion during STREAM does not interrupt the burst.
- out_base is 0 whenever out_busy is 0.
- Simultaneous events: a bank freed in the same cycle as a write-side full event is visible to in_ready in the next cycle. The write to one bank and the stream from the other run concurrently with no conflict.
- Latency: the first out_start occurs 1 cycle after in_last transfers, provided the read side is IDLE and down_wait is 0.

Test Plan:
- READ_LEN=8; send "ACGTACGT" with in_last on the final byte, down_wait=0 -> out_start pulses 1 cycle after the last transfer; out_base = 0,1,2,3,0,1,2,3 over 8 consecutive cycles with out_busy=1; then out_base=0 and out_busy=0; all counters 0.
- Send "acgN" + last -> bases 0,1,2,0,0,0,0,0; bad_char_cnt=1; pad_cnt=1.
- Send 11 chars "TTTTTTTTGGG" + last -> bases 3×8; trunc_cnt=1; the next read is unaffected.
- Hold down_wait=1 and send three full reads -> in_ready drops after the second read is buffered; no out_start. Release down_wait -> two bursts, each separated by exactly one idle cycle; in_ready rises after the first burst ends.
- Raise down_wait during STREAM cycle 3 -> burst completes all 8 bases; the next burst is held until down_wait=0.
- Assert rst_n=0 at STREAM cycle 4 -> out_busy and out_base are 0 immediately; after release there is no residual burst and the counters read 0.
